game_tick_receiver: RTL and testbench
=====================================

# game_tick_receiver

Fast-domain consumer of the divided game clock produced by the clock divider. It synchronises the slow clock level into `clk`, detects its rising edges, and emits one-cycle `tick` strobes. Every `TICKS_PER_STEP` ticks it raises a held `step_pending` request toward the game-state logic, which acknowledges it. A watchdog flags a stalled divider. It is the single point where game logic learns that time has advanced.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchroniser flops on `slow_clk_in`; legal range is 2 to 4.
- `TICKS_PER_STEP`, 4: ticks per step request; legal range is 1 to 255.
- `TIMEOUT_CYCLES`, 32'd120_000_000: `clk` cycles without a rising edge before a stall is declared; must be at least 2.

Ports:
- `clk` in 1: system clock. The single clock of the block.
- `rst` in 1: reset, asynchronous and active-high.
- `slow_clk_in` in 1: divided clock level, asynchronous to `clk`.
- `run` in 1: level input. 1 lets ticks count toward steps.
- `step_ack` in 1: one-cycle acknowledge from the game logic.
- `clear` in 1: one-cycle pulse that clears `overrun` and `stalled`.
- `tick` out 1: one-cycle strobe per rising edge of `slow_clk_in`.
- `step_pending` out 1: step request, held until acknowledged.
- `tick_count` out 16: free-running count of ticks.
- `overrun` out 1: sticky. A step came due while one was still pending.
- `stalled` out 1: sticky. The watchdog expired.

## Operation

- **Synchroniser.** `slow_clk_in` passes through `SYNC_STAGES` flops, then one history flop. A rising edge is `sync_last & ~hist`. `tick` is registered from that edge.
- **Tick counter.** `tick_count` increments on every `tick`, regardless of `run` or state. It wraps from 16'hFFFF to 0.
- **State machine.** States are IDLE, RUN and STALL.
  - IDLE → RUN when `run`=1.
  - RUN → IDLE when `run`=0. This also zeroes the step prescaler.
  - RUN → STALL when the watchdog expires.
  - STALL → RUN when `tick` and `run`=1.
  - STALL → IDLE when `tick` and `run`=0.
  - `clear` does not change the state.
- **Step prescaler.** An 8-bit counter advances on `tick` in RUN only. When it reaches `TICKS_PER_STEP`-1 on a tick, it wraps to 0 and a step comes due.
- **Step handshake.**
  - A due step sets `step_pending`.
  - If `step_pending` is already 1 and not being acked in the same cycle, `overrun` is set instead. `step_pending` stays 1 and no step is queued.
  - If a step comes due in the same cycle as `step_ack`, `step_pending` stays 1 (the new request replaces the acked one) and there is no overrun.
  - `step_ack` while `step_pending`=0 is ignored.
- **Watchdog.** A 32-bit counter zeroes on every `tick` and increments otherwise. It is active in RUN and STALL and held at 0 in IDLE. When it reaches `TIMEOUT_CYCLES`-1, it sets `stalled` and the state goes to STALL. In STALL it saturates and does not re-fire.
- **clear.** Clears `overrun` and `stalled`. If a set event occurs in the same cycle, the set wins.

## Timing

- **Reset values.** All outputs are 0, state is IDLE, and every counter and synchroniser flop is 0. Reset takes effect immediately and asynchronously, including mid-step-pending; a pending step is discarded.
- **Tick latency.** With `slow_clk_in` first sampled high at edge k, `tick` is high during the cycle following edge k+`SYNC_STAGES`. It is exactly one cycle wide, and there is one strobe per slow rising edge.
- **Step latency.** `step_pending` rises the cycle after the due tick, so two cycles after the tick edge. It falls the cycle after a `step_ack` edge.
- **Stall latency.** `stalled` rises on the edge after the counter reaches `TIMEOUT_CYCLES`-1, i.e. `TIMEOUT_CYCLES` cycles after the last tick or after leaving IDLE.
- **Glitch handling.** A `slow_clk_in` glitch shorter than one `clk` period may produce at most one tick. The block is not required to filter glitches.

## Structure

- A shared package holds:
  - the state enum `tick_state_t` (IDLE, RUN, STALL);
  - the widths `TICK_CNT_W`=16, `PRESCALE_W`=8 and `WDOG_W`=32.
- One sub-module: `sync_rise_detect`, parameterised by `SYNC_STAGES`. It outputs the registered one-cycle rising-edge strobe and is reusable for the button inputs.

## Test plan

Benches use `SYNC_STAGES`=2, `TICKS_PER_STEP`=3 and `TIMEOUT_CYCLES`=20.

1. **Tick latency.** Release reset, then raise `slow_clk_in` at edge 5 → `tick` is high only in the cycle after edge 7; `tick_count`=1.
2. **Step handshake.** Hold `run`=1 and apply 3 slow edges → `step_pending`=1 two cycles after the third tick. Pulse `step_ack` → `step_pending`=0 next cycle and `overrun`=0.
3. **Overrun.** Apply 6 ticks with no ack → `step_pending`=1 and `overrun`=1 after the 6th tick. Pulse `clear` → `overrun`=0 and `step_pending` stays 1.
4. **Due step with same-cycle ack.** Assert `step_ack` in the same cycle a step comes due → `step_pending` stays 1 and `overrun`=0.
5. **Stall and recovery.** With `run`=1, stop `slow_clk_in` → `stalled`=1 20 cycles after the last tick. The next tick returns the state to RUN; `stalled` stays 1 until `clear`.
6. **Reset mid-operation.** Assert `rst` asynchronously while `step_pending`=1 and `tick_count`=57 → all outputs are 0 immediately, before the next `clk` edge.

Source files
------------

// File: rtl/game_tick_receiver_pkg.sv
// Shared types and widths for the game tick receiver.
package game_tick_receiver_pkg;

  localparam int unsigned TICK_CNT_W = 16;
  localparam int unsigned PRESCALE_W = 8;
  localparam int unsigned WDOG_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } tick_state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchroniser for an asynchronous level, followed by a
// registered one-cycle rising-edge strobe.
module sync_rise_detect
  import game_tick_receiver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/game_tick_receiver.sv
// Turns the divided game clock into tick strobes, step requests with an
// ack handshake, and a watchdog that flags a stalled divider.
module game_tick_receiver
  import game_tick_receiver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TICKS_PER_STEP = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32'd120_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  slow_clk_in,
  input  logic                  run,
  input  logic                  step_ack,
  input  logic                  clear,
  output logic                  tick,
  output logic                  step_pending,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  overrun,
  output logic                  stalled
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_STEP - 1);
  localparam logic [WDOG_W-1:0]     WDOG_LAST  = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic                  w_tick;
  logic                  w_step_due;
  logic                  w_wdog_fire;
  tick_state_t           r_state;
  logic [PRESCALE_W-1:0] r_presc;
  logic [WDOG_W-1:0]     r_wdog;
  logic [TICK_CNT_W-1:0] r_tick_count;
  logic                  r_pending;
  logic                  r_overrun;
  logic                  r_stalled;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(slow_clk_in),
    .o_rise (w_tick)
  );

  // Dropping run has priority over both a due step and a watchdog expiry.
  assign w_step_due  = (r_state == RUN) & run & w_tick & (r_presc == PRESC_LAST);
  assign w_wdog_fire = (r_state == RUN) & run & ~w_tick & (r_wdog == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_wdog       <= '0;
      r_tick_count <= '0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_stalled    <= 1'b0;
    end else begin
      if (w_tick) r_tick_count <= r_tick_count + 1'b1;

      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (run) r_state <= RUN;
        end
        RUN: begin
          if (!run) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_wdog  <= '0;
          end else if (w_tick) begin
            r_wdog  <= '0;
            r_presc <= w_step_due ? '0 : r_presc + 1'b1;
          end else if (w_wdog_fire) begin
            r_state <= STALL;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        STALL: begin
          // Counter saturates here so the watchdog cannot fire twice.
          if (w_tick) begin
            r_wdog  <= '0;
            r_state <= run ? RUN : IDLE;
          end else if (r_wdog != WDOG_LAST) begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A due step replaces an acked one; acking an empty slot is a no-op.
      if (w_step_due)    r_pending <= 1'b1;
      else if (step_ack) r_pending <= 1'b0;

      if (w_step_due & r_pending & ~step_ack) r_overrun <= 1'b1;
      else if (clear)                         r_overrun <= 1'b0;

      if (w_wdog_fire) r_stalled <= 1'b1;
      else if (clear)  r_stalled <= 1'b0;
    end
  end

  assign tick         = w_tick;
  assign step_pending = r_pending;
  assign tick_count   = r_tick_count;
  assign overrun      = r_overrun;
  assign stalled      = r_stalled;

endmodule

// File: tb/tb_game_tick_receiver.sv
// Directed plus randomized bench for game_tick_receiver, checked every
// cycle against a sample-based reference model.
module tb_game_tick_receiver;

  localparam int unsigned SS  = 2;
  localparam int unsigned TPS = 3;
  localparam int unsigned TO  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        slow_clk_in;
  logic        run;
  logic        step_ack;
  logic        clear;
  logic        tick;
  logic        step_pending;
  logic [15:0] tick_count;
  logic        overrun;
  logic        stalled;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle 1=running 2=stalled.
  int m_mode, m_presc, m_wd, m_cnt;
  bit m_tick, m_pend, m_ovr, m_stall;
  bit s_hist [6];

  game_tick_receiver #(
    .SYNC_STAGES   (SS),
    .TICKS_PER_STEP(TPS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slow_clk_in (slow_clk_in),
    .run         (run),
    .step_ack    (step_ack),
    .clear       (clear),
    .tick        (tick),
    .step_pending(step_pending),
    .tick_count  (tick_count),
    .overrun     (overrun),
    .stalled     (stalled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_presc = 0; m_wd = 0; m_cnt = 0;
    m_tick = 0; m_pend = 0; m_ovr = 0; m_stall = 0;
    for (int i = 0; i < 6; i++) s_hist[i] = 1'b0;
  endtask

  // Advance the model across one rising clock edge using the current inputs.
  task automatic model_edge();
    bit due, fire, new_tick;
    due  = 1'b0;
    fire = 1'b0;
    for (int i = 5; i > 0; i--) s_hist[i] = s_hist[i-1];
    s_hist[0] = slow_clk_in;
    new_tick = s_hist[SS] && !s_hist[SS+1];

    if (m_tick) m_cnt = (m_cnt + 1) % 65536;

    case (m_mode)
      0: begin
        m_wd = 0;
        if (run) m_mode = 1;
      end
      1: begin
        if (!run) begin
          m_mode = 0; m_presc = 0; m_wd = 0;
        end else if (m_tick) begin
          m_wd = 0;
          if (m_presc == TPS - 1) begin m_presc = 0; due = 1'b1; end
          else m_presc++;
        end else if (m_wd == TO - 1) begin
          m_mode = 2; fire = 1'b1;
        end else m_wd++;
      end
      default: begin
        if (m_tick) begin m_wd = 0; m_mode = run ? 1 : 0; end
        else if (m_wd < TO - 1) m_wd++;
      end
    endcase

    if (due && m_pend && !step_ack) m_ovr = 1'b1;
    else if (clear) m_ovr = 1'b0;
    if (due) m_pend = 1'b1;
    else if (step_ack) m_pend = 1'b0;
    if (fire) m_stall = 1'b1;
    else if (clear) m_stall = 1'b0;

    m_tick = new_tick;
  endtask

  task automatic check_all();
    chk("tick",         32'(tick),         32'(m_tick));
    chk("step_pending", 32'(step_pending), 32'(m_pend));
    chk("tick_count",   32'(tick_count),   32'(m_cnt));
    chk("overrun",      32'(overrun),      32'(m_ovr));
    chk("stalled",      32'(stalled),      32'(m_stall));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    slow_clk_in = 1'b1;
    cyc(hi);
    slow_clk_in = 1'b0;
    cyc(lo);
  endtask

  initial begin
    int guard;
    int prob;
    rst = 1'b1; slow_clk_in = 1'b0; run = 1'b0; step_ack = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Tick latency: first sampled high at edge 5, strobe after edge 7.
    cyc(4);
    slow_clk_in = 1'b1;
    cyc(3);
    chk("t1_tick_high", 32'(tick), 32'd1);
    cyc(1);
    chk("t1_tick_low", 32'(tick), 32'd0);
    chk("t1_count", 32'(tick_count), 32'd1);
    slow_clk_in = 1'b0;
    cyc(2);

    // Step handshake.
    run = 1'b1;
    cyc(1);
    repeat (3) pulse(3, 3);
    chk("t2_pending", 32'(step_pending), 32'd1);
    step_ack = 1'b1;
    cyc(1);
    step_ack = 1'b0;
    chk("t2_acked", 32'(step_pending), 32'd0);
    chk("t2_no_ovr", 32'(overrun), 32'd0);

    // Overrun, then clear.
    repeat (6) pulse(3, 3);
    chk("t3_pending", 32'(step_pending), 32'd1);
    chk("t3_ovr", 32'(overrun), 32'd1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t3_ovr_clr", 32'(overrun), 32'd0);
    chk("t3_pend_kept", 32'(step_pending), 32'd1);

    // Ack in the same cycle a step comes due.
    repeat (2) pulse(3, 3);
    slow_clk_in = 1'b1;
    cyc(3);
    chk("t4_tick", 32'(tick), 32'd1);
    step_ack = 1'b1;
    cyc(1);
    step_ack = 1'b0;
    chk("t4_pending", 32'(step_pending), 32'd1);
    chk("t4_no_ovr", 32'(overrun), 32'd0);
    slow_clk_in = 1'b0;
    cyc(3);

    // Stall and recovery.
    cyc(25);
    chk("t5_stalled", 32'(stalled), 32'd1);
    pulse(3, 3);
    chk("t5_sticky", 32'(stalled), 32'd1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t5_clr", 32'(stalled), 32'd0);

    // Reach tick_count 57 with a step pending, then reset asynchronously.
    guard = 0;
    while (m_cnt != 57 && guard < 100) begin
      pulse(2, 2);
      guard++;
    end
    chk("t6_count", 32'(tick_count), 32'd57);
    chk("t6_pending", 32'(step_pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tick", 32'(tick), 32'd0);
    chk("t6_rst_pend", 32'(step_pending), 32'd0);
    chk("t6_rst_count", 32'(tick_count), 32'd0);
    chk("t6_rst_ovr", 32'(overrun), 32'd0);
    chk("t6_rst_stall", 32'(stalled), 32'd0);
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Randomized traffic in segments of varying slow-clock activity.
    for (int seg = 0; seg < 12; seg++) begin
      case ($urandom_range(3))
        0:       prob = 0;
        1:       prob = 15;
        2:       prob = 35;
        default: prob = 60;
      endcase
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(99) < prob) slow_clk_in = ~slow_clk_in;
        step_ack = ($urandom_range(5) == 0);
        clear    = ($urandom_range(19) == 0);
        if ($urandom_range(39) == 0) run = ~run;
        cyc(1);
      end
    end
    step_ack = 1'b0;
    clear    = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
